rcvr_fifo: RTL

Parametrised serial frame receiver: hunts a one-bit-per-clock input stream for a configurable header pattern, deserialises the following DATA_W-bit body into a word, and queues completed words in a DEPTH-entry show-ahead FIFO for the consumer. It generalises the single-buffer receiver with configurable header/data widths, selectable bit order, multi-word buffering, a fill level and a busy indication. It sits between the serial line sampler and the word-level consumer.

---
 rtl/rcvr_fifo.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/rcvr_fifo.sv
// rcvr_fifo: serial frame receiver with header hunt and show-ahead word FIFO.
// Hunts data_in for MATCH, deserialises a DATA_W-bit body, queues words.
//
// Ports:
//   clock     in   rising-edge clock
//   reset     in   asynchronous active-high reset
//   data_in   in   serial data, one bit per clock
//   reading   in   consumer pop strobe (ignored while empty)
//   ready     out  FIFO holds at least one word
//   overrun   out  sticky: a completed word was dropped on a full FIFO
//   data_out  out  head word of the FIFO (show-ahead), 0 when empty
//   level     out  number of queued words
//   busy      out  body bits are being shifted in
module rcvr_fifo #(
    parameter int                HEAD_W    = 8,
    parameter logic [HEAD_W-1:0] MATCH     = 8'hA5,
    parameter int                DATA_W    = 8,
    parameter int                DEPTH     = 4,
    parameter bit                MSB_FIRST = 1'b1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     data_in,
    input  logic                     reading,
    output logic                     ready,
    output logic                     overrun,
    output logic [DATA_W-1:0]        data_out,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;
    localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] LAST     = CNT_W'(DATA_W - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    // The shift register is preloaded with the complement of the first
    // header bit so stale content can never complete a header early.
    localparam logic [HEAD_W-2:0] HEAD_RST = {(HEAD_W-1){~MATCH[HEAD_W-1]}};

    localparam logic [0:0] PH_HEAD = 1'b0;
    localparam logic [0:0] PH_BODY = 1'b1;

    // ------------------------------------------------------------------
    // Receiver state
    // ------------------------------------------------------------------
    logic [0:0]        r_phase;
    logic [HEAD_W-2:0] r_head;
    logic [DATA_W-2:0] r_body;
    logic [CNT_W-1:0]  r_count;

    logic [HEAD_W-1:0] w_head_cat;
    logic              w_hit;
    logic              w_last;
    logic [DATA_W-1:0] w_word;
    logic [DATA_W-2:0] w_body_nxt;

    assign w_head_cat = {r_head, data_in};
    assign w_hit      = (r_phase == PH_HEAD) && (w_head_cat == MATCH);
    assign w_last     = (r_phase == PH_BODY) && (r_count == LAST);

    // MSB-first shifts left (oldest bit ends at the top); LSB-first
    // shifts right so the oldest bit ends at bit 0.
    assign w_word     = MSB_FIRST ? {r_body, data_in} : {data_in, r_body};
    assign w_body_nxt = MSB_FIRST ? w_word[DATA_W-2:0]
                                  : w_word[DATA_W-1:1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_phase <= PH_HEAD;
            r_head  <= HEAD_RST;
            r_body  <= '0;
            r_count <= '0;
        end else begin
            case (r_phase)
                PH_HEAD: begin
                    if (w_hit) begin
                        r_phase <= PH_BODY;
                        r_head  <= HEAD_RST;
                    end else begin
                        r_head  <= w_head_cat[HEAD_W-2:0];
                    end
                end
                PH_BODY: begin
                    r_body <= w_body_nxt;
                    if (w_last) begin
                        r_phase <= PH_HEAD;
                        r_count <= '0;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                default: begin
                    r_phase <= PH_HEAD;
                end
            endcase
        end
    end

    assign busy = (r_phase == PH_BODY);

    // ------------------------------------------------------------------
    // Word FIFO
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr;
    logic [AW-1:0]     r_rd;
    logic [LVL_W-1:0]  r_level;
    logic              r_ready;
    logic              r_overrun;
    logic [DATA_W-1:0] r_dout;

    logic              w_pop;
    logic              w_full;
    logic              w_wr_en;
    logic              w_drop;
    logic [AW-1:0]     w_rd_nxt;
    logic [AW-1:0]     w_wr_nxt;
    logic [LVL_W-1:0]  w_lvl_nxt;
    logic [DATA_W-1:0] w_head_nxt;

    assign w_pop    = reading && r_ready;
    assign w_full   = (r_level == LVL_FULL);
    // A simultaneous pop frees the slot the new word needs.
    assign w_wr_en  = w_last && (!w_full || w_pop);
    assign w_drop   = w_last && w_full && !w_pop;
    assign w_rd_nxt = w_pop   ? r_rd + 1'b1 : r_rd;
    assign w_wr_nxt = w_wr_en ? r_wr + 1'b1 : r_wr;

    always_comb begin
        w_lvl_nxt = r_level;
        case ({w_wr_en, w_pop})
            2'b10:   w_lvl_nxt = r_level + 1'b1;
            2'b01:   w_lvl_nxt = r_level - 1'b1;
            default: w_lvl_nxt = r_level;
        endcase
    end

    // Next head word: the word being written this edge becomes the head
    // when every older entry is gone, otherwise the head comes from memory.
    always_comb begin
        w_head_nxt = '0;
        if (w_lvl_nxt == '0) begin
            w_head_nxt = '0;
        end else if (w_wr_en && (w_rd_nxt == r_wr)) begin
            w_head_nxt = w_word;
        end else begin
            w_head_nxt = r_mem[w_rd_nxt];
        end
    end

    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            r_mem[r_wr] <= w_word;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
            r_ready <= 1'b0;
            r_dout  <= '0;
        end else begin
            r_wr    <= w_wr_nxt;
            r_rd    <= w_rd_nxt;
            r_level <= w_lvl_nxt;
            r_ready <= (w_lvl_nxt != '0);
            r_dout  <= w_head_nxt;
        end
    end

    // A drop needs a full FIFO with no pop, so it never meets a clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else if (reading) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end
    end

    assign ready    = r_ready;
    assign overrun  = r_overrun;
    assign data_out = r_dout;
    assign level    = r_level;

endmodule
